// File: rtl/spi_xact_ctrl_pkg.sv
// Shared encodings for the SPI transaction sequencer:
// FSM states, phase codes and phase bookkeeping helpers.
package spi_ctrl_defs;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_REQ    = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  localparam logic [1:0] PH_CMD  = 2'd0;
  localparam logic [1:0] PH_ADDR = 2'd1;
  localparam logic [1:0] PH_DATA = 2'd2;
  localparam logic [1:0] PH_END  = 2'd3;

  // Next non-empty phase after ph; PH_END when nothing remains.
  function automatic logic [1:0] next_phase(
    input logic [1:0] ph,
    input logic [1:0] ab,
    input logic [7:0] len
  );
    logic [1:0] nx;
    nx = PH_END;
    if (ph == PH_CMD && ab != 2'd0)
      nx = PH_ADDR;
    else if (ph != PH_DATA && len != 8'd0)
      nx = PH_DATA;
    return nx;
  endfunction

  function automatic logic [7:0] phase_cnt(
    input logic [1:0] ph,
    input logic [1:0] ab,
    input logic [7:0] len
  );
    logic [7:0] c;
    case (ph)
      PH_ADDR: c = {6'd0, ab};
      PH_DATA: c = len;
      default: c = 8'd1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/spi_xact_ctrl.sv
// Expands one host command into byte requests for the SPI engine,
// streaming write payload in and read payload out.
module spi_xact_ctrl
  import spi_ctrl_defs::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [23:0] addr,
  input  logic [1:0]  addr_bytes,
  input  logic [7:0]  len,
  input  logic        is_read,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        spi_read,
  output logic        spi_write,
  output logic [7:0]  spi_din,
  input  logic [7:0]  spi_dout,
  input  logic        spi_busy
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d;
  logic [1:0]  ab_q, ab_d;
  logic [7:0]  len_q, len_d;
  logic        rd_q, rd_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  rdd_q, rdd_d;
  logic        rdv_q, rdv_d;
  logic        err_q, err_d;

  logic       accept;
  logic       data_rd;
  logic [7:0] addr_byte;
  logic [1:0] nph;

  assign accept  = start &&
                   (state_q == ST_IDLE || state_q == ST_FINISH);
  assign data_rd = (phase_q == PH_DATA) && rd_q;
  assign nph     = next_phase(phase_q, ab_q, len_q);

  always_comb begin
    unique case (1'b1)
      (cnt_q == 8'd3): addr_byte = addr_q[23:16];
      (cnt_q == 8'd2): addr_byte = addr_q[15:8];
      default:         addr_byte = addr_q[7:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    ab_d    = ab_q;
    len_d   = len_q;
    rd_d    = rd_q;
    byte_d  = byte_q;
    rdd_d   = rdd_q;
    rdv_d   = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_FINISH: begin
        state_d = ST_IDLE;
        if (accept) begin
          cmd_d   = cmd;
          addr_d  = addr;
          ab_d    = addr_bytes;
          len_d   = len;
          rd_d    = is_read;
          err_d   = 1'b0;
          phase_d = PH_CMD;
          cnt_d   = 8'd1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tmo_d = 8'd0;
        unique case (1'b1)
          (phase_q == PH_END): state_d = ST_FINISH;
          (phase_q == PH_CMD): begin
            byte_d  = cmd_q;
            state_d = ST_REQ;
          end
          (phase_q == PH_ADDR): begin
            byte_d  = addr_byte;
            state_d = ST_REQ;
          end
          default: begin
            if (rd_q) begin
              byte_d  = 8'd0;
              state_d = ST_REQ;
            end else if (wr_valid) begin
              byte_d  = wr_data;
              state_d = ST_REQ;
            end
          end
        endcase
      end
      ST_REQ: begin
        if (spi_busy) begin
          state_d = ST_WAIT;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_WAIT: begin
        if (!spi_busy) begin
          if (data_rd) begin
            rdd_d = spi_dout;
            rdv_d = 1'b1;
          end
          // Last byte of a phase: jump straight past empty phases.
          if (cnt_q > 8'd1) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            phase_d = nph;
            cnt_d   = phase_cnt(nph, ab_q, len_q);
          end
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= PH_CMD;
      cnt_q   <= 8'd0;
      tmo_q   <= 8'd0;
      cmd_q   <= 8'd0;
      addr_q  <= 24'd0;
      ab_q    <= 2'd0;
      len_q   <= 8'd0;
      rd_q    <= 1'b0;
      byte_q  <= 8'd0;
      rdd_q   <= 8'd0;
      rdv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ab_q    <= ab_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      byte_q  <= byte_d;
      rdd_q   <= rdd_d;
      rdv_q   <= rdv_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == ST_LOAD) || (state_q == ST_REQ) ||
                     (state_q == ST_WAIT);
  assign done      = (state_q == ST_FINISH);
  assign err       = err_q;
  assign wr_ready  = (state_q == ST_LOAD) && (phase_q == PH_DATA) && !rd_q;
  assign spi_write = (state_q == ST_REQ) && !data_rd;
  assign spi_read  = (state_q == ST_REQ) && data_rd;
  assign spi_din   = spi_write ? byte_q : 8'd0;
  assign rd_data   = rdd_q;
  assign rd_valid  = rdv_q;

endmodule

// File: tb/tb_spi_xact_ctrl.sv
// Directed bench for spi_xact_ctrl with a behavioural SPI engine
// and a write-payload source that can stall.
module tb_spi_xact_ctrl;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  cmd;
  logic [23:0] addr;
  logic [1:0]  addr_bytes;
  logic [7:0]  len;
  logic        is_read;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        err;
  logic        spi_read;
  logic        spi_write;
  logic [7:0]  spi_din;
  logic [7:0]  spi_dout;
  logic        spi_busy;

  int total  = 0;
  int passed = 0;

  logic [8:0] elog[$];
  logic [7:0] rlog[$];
  logic [7:0] rsp[$];
  logic [7:0] wsrc[$];
  int         ecnt;
  bit         dead;
  int         done_cnt;
  int         whi;
  int         both_hi;
  int         stall_left;

  spi_xact_ctrl #(.TIMEOUT(64)) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .cmd(cmd),
    .addr(addr), .addr_bytes(addr_bytes), .len(len),
    .is_read(is_read), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .err(err), .spi_read(spi_read),
    .spi_write(spi_write), .spi_din(spi_din), .spi_dout(spi_dout),
    .spi_busy(spi_busy)
  );

  always #5 clk_in = ~clk_in;

  // Engine: accepts a request, stays busy for 3 cycles.
  always @(posedge clk_in) begin
    if (reset) begin
      spi_busy <= 1'b0;
      ecnt     <= 0;
    end else if (spi_busy) begin
      if (ecnt == 0) spi_busy <= 1'b0;
      else ecnt <= ecnt - 1;
    end else if ((spi_write || spi_read) && !dead) begin
      elog.push_back({spi_read, spi_din});
      if (spi_read)
        spi_dout <= (rsp.size() > 0) ? rsp.pop_front() : 8'hEE;
      spi_busy <= 1'b1;
      ecnt     <= 2;
    end
  end

  always @(posedge clk_in) begin
    if (rd_valid) rlog.push_back(rd_data);
    if (done) done_cnt <= done_cnt + 1;
    if (spi_write) whi <= whi + 1;
    if (spi_write && spi_read) both_hi <= both_hi + 1;
    if (stall_left > 0) stall_left <= stall_left - 1;
    if (wr_valid && wr_ready) begin
      if (wsrc.pop_front() == 8'h11) stall_left <= 20;
    end
  end

  always @(negedge clk_in) begin
    wr_valid <= (wsrc.size() > 0) && (stall_left == 0);
    wr_data  <= (wsrc.size() > 0) ? wsrc[0] : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [7:0] c, input logic [23:0] a,
                       input logic [1:0] ab, input logic [7:0] l,
                       input logic r);
    @(negedge clk_in);
    start = 1'b1; cmd = c; addr = a; addr_bytes = ab;
    len = l; is_read = r;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is high (or after lim cycles).
  task automatic wait_done(input string tag, input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      if (done) ok = 1'b1;
      else @(negedge clk_in);
    end
    chk(tag, ok, 1);
  endtask

  task automatic chk_log(input string tag, input logic [8:0] exp[$]);
    chk({tag, "_n"}, elog.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < elog.size()) chk(tag, elog[i], exp[i]);
  endtask

  logic [8:0] ex[$];
  int d0;
  int r0;
  bit hit;

  initial begin
    reset = 1'b1; start = 1'b0; cmd = 8'h0; addr = 24'h0;
    addr_bytes = 2'd0; len = 8'd0; is_read = 1'b0;
    dead = 1'b0; done_cnt = 0; whi = 0; both_hi = 0;
    stall_left = 0; spi_dout = 8'h0;
    repeat (3) @(negedge clk_in);
    chk("reset_outs", {busy, done, err, wr_ready, rd_valid, rd_data,
                       spi_read, spi_write, spi_din}, 0);
    reset = 1'b0;

    // Write enable
    elog.delete(); rlog.delete();
    issue(8'h06, 24'h0, 2'd0, 8'd0, 1'b0);
    chk("wren_busy", busy, 1);
    wait_done("wren_done", 100);
    chk("wren_err", err, 0);
    chk("wren_busy0", busy, 0);
    ex = '{9'h006};
    chk_log("wren_log", ex);
    chk("wren_rdv", rlog.size(), 0);

    // Read 2 bytes at 0x012345
    elog.delete(); rlog.delete();
    rsp = '{8'hA5, 8'h5A};
    issue(8'h03, 24'h012345, 2'd3, 8'd2, 1'b1);
    wait_done("rd_done", 200);
    chk("rd_err", err, 0);
    ex = '{9'h003, 9'h001, 9'h023, 9'h045, 9'h100, 9'h100};
    chk_log("rd_log", ex);
    chk("rd_n", rlog.size(), 2);
    if (rlog.size() == 2) begin
      chk("rd_b0", rlog[0], 8'hA5);
      chk("rd_b1", rlog[1], 8'h5A);
    end

    // Page program with a 20-cycle underrun before 0x22
    elog.delete(); rlog.delete();
    wsrc = '{8'h11, 8'h22, 8'h33};
    issue(8'h02, 24'h00BEEF, 2'd2, 8'd3, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk_in);
      if (stall_left == 5) hit = 1'b1;
    end
    chk("pp_stall_seen", hit, 1);
    chk("pp_stall_log", elog.size(), 4);
    chk("pp_stall_req", {spi_write, spi_read}, 0);
    chk("pp_stall_rdy", wr_ready, 1);
    wait_done("pp_done", 300);
    chk("pp_err", err, 0);
    ex = '{9'h002, 9'h0BE, 9'h0EF, 9'h011, 9'h022, 9'h033};
    chk_log("pp_log", ex);

    // Dead engine
    elog.delete();
    dead = 1'b1;
    @(negedge clk_in);
    whi = 0;
    issue(8'h06, 24'h0, 2'd0, 8'd0, 1'b0);
    wait_done("dead_done", 200);
    chk("dead_err", err, 1);
    chk("dead_busy", busy, 0);
    chk("dead_whi", whi, 64);
    dead = 1'b0;
    @(negedge clk_in);
    chk("dead_err_sticky", err, 1);

    // Start while busy is ignored; err clears on accept
    elog.delete();
    d0 = done_cnt;
    issue(8'h05, 24'h000077, 2'd1, 8'd0, 1'b0);
    chk("ign_err_clr", err, 0);
    @(negedge clk_in);
    start = 1'b1; cmd = 8'hAB; addr_bytes = 2'd0;
    @(negedge clk_in);
    start = 1'b0;
    wait_done("ign_done", 200);
    repeat (30) @(negedge clk_in);
    ex = '{9'h005, 9'h077};
    chk_log("ign_log", ex);
    chk("ign_done_n", done_cnt - d0, 1);

    // Reset during the second read payload byte
    elog.delete(); rlog.delete();
    rsp = '{8'hA5, 8'h5A};
    issue(8'h03, 24'h012345, 2'd3, 8'd2, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk_in);
      if (elog.size() == 6) hit = 1'b1;
    end
    chk("rst_reached", hit, 1);
    d0 = done_cnt;
    r0 = rlog.size();
    reset = 1'b1;
    @(negedge clk_in);
    chk("rst_outs", {busy, done, err, wr_ready, rd_valid, rd_data,
                     spi_read, spi_write, spi_din}, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk_in);
    chk("rst_rdv", rlog.size(), r0);
    chk("rst_rdv1", r0, 1);
    chk("rst_done", done_cnt, d0);

    elog.delete();
    issue(8'h06, 24'h0, 2'd0, 8'd0, 1'b0);
    wait_done("rst_wren_done", 100);
    chk("rst_wren_err", err, 0);
    ex = '{9'h006};
    chk_log("rst_wren_log", ex);

    chk("rw_exclusive", both_hi, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
